// File: rtl/decoder_erasure_flag_reader_pkg.sv
// Shared definitions for the erasure-flag RAM reader and writer sides:
// state encoding and default geometry of the per-codeword flag RAM.
package decoder_erasure_flag_reader_pkg;

  localparam int ERAS_ADDR_W = 8;
  localparam int ERAS_MAX    = 16;
  localparam int ERAS_CNT_W  = 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } rd_state_t;

endpackage

// File: rtl/decoder_erasure_flag_reader_erasure_pos_fifo.sv
// Two-entry position FIFO; skid buffer that absorbs the one-cycle flag RAM
// read latency while the locator stage applies backpressure.
module erasure_pos_fifo #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic         o_valid,
  output logic [W-1:0] o_head,
  output logic [1:0]   o_count
);

  logic [W-1:0] r_mem [2];
  logic         r_wr;
  logic         r_rd;
  logic [1:0]   r_cnt;
  logic         w_do_push;
  logic         w_do_pop;

  assign w_do_pop  = i_pop && (r_cnt != 2'd0);
  assign w_do_push = i_push && ((r_cnt != 2'd2) || w_do_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 2; i++) r_mem[i] <= '0;
      r_wr  <= 1'b0;
      r_rd  <= 1'b0;
      r_cnt <= 2'd0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= ~r_wr;
      end
      if (w_do_pop) r_rd <= ~r_rd;
      r_cnt <= r_cnt + {1'b0, w_do_push} - {1'b0, w_do_pop};
    end
  end

  assign o_valid = (r_cnt != 2'd0);
  assign o_head  = r_mem[r_rd];
  assign o_count = r_cnt;

endmodule

// File: rtl/decoder_erasure_flag_reader.sv
// Scans the erasure-flag RAM of one codeword and streams the address of each
// set flag to the erasure locator, counting erasures and flagging overflow.
module decoder_erasure_flag_reader
  import decoder_erasure_flag_reader_pkg::*;
#(
  parameter int ADDR_W   = ERAS_ADDR_W,
  parameter int MAX_ERAS = ERAS_MAX,
  parameter int CNT_W    = ERAS_CNT_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] cw_len,
  output logic              rden,
  output logic [ADDR_W-1:0] rdaddress,
  input  logic              q,
  output logic              loc_valid,
  input  logic              loc_ready,
  output logic [ADDR_W-1:0] loc_pos,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  eras_count,
  output logic              overflow
);

  localparam logic [ADDR_W-1:0] ONE     = ADDR_W'(1);
  localparam logic [CNT_W-1:0]  CNT_SAT = CNT_W'(2 ** ADDR_W);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_ERAS);

  rd_state_t         r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] r_len;
  logic [ADDR_W-1:0] r_rdaddr;
  logic              r_infl;
  logic              r_busy;
  logic              r_done;
  logic              r_ovf;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_fifo_valid;
  logic [ADDR_W-1:0] w_fifo_head;
  logic [1:0]        w_fifo_cnt;
  logic [1:0]        w_occ_eff;
  logic [1:0]        w_fifo_next;
  logic [2:0]        w_budget;
  logic              w_pop;
  logic              w_push;
  logic              w_hit;
  logic              w_issue;
  logic              w_last;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= CNT_SAT) ? CNT_SAT : v + 1'b1;
  endfunction

  // Occupancy is taken after this cycle's pop so a steady stream keeps one
  // read per cycle; the in-flight read will land in a slot that is free.
  assign w_pop       = w_fifo_valid && loc_ready;
  assign w_occ_eff   = w_fifo_cnt - {1'b0, w_pop};
  assign w_budget    = {1'b0, w_occ_eff} + {2'b00, r_infl};
  assign w_issue     = (r_state == ST_SCAN) && (w_budget < 3'd2);
  assign w_last      = (r_ptr == (r_len - ONE));
  assign w_hit       = r_infl && q;
  assign w_push      = w_hit && (r_cnt < CNT_MAX);
  assign w_fifo_next = w_fifo_cnt + {1'b0, w_push} - {1'b0, w_pop};

  erasure_pos_fifo #(
    .W (ADDR_W)
  ) u_pos_fifo (
    .i_clk   (clock),
    .i_rst_n (reset_n),
    .i_push  (w_push),
    .i_data  (r_rdaddr),
    .i_pop   (w_pop),
    .o_valid (w_fifo_valid),
    .o_head  (w_fifo_head),
    .o_count (w_fifo_cnt)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_ptr    <= '0;
      r_len    <= '0;
      r_rdaddr <= '0;
      r_infl   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_infl <= w_issue;
      r_done <= 1'b0;
      if (w_issue) begin
        r_rdaddr <= r_ptr;
        r_ptr    <= r_ptr + ONE;
      end
      // Read return: every hit is counted, only the first MAX_ERAS are forwarded.
      if (w_hit) begin
        r_cnt <= sat_inc(r_cnt);
        if (!w_push) r_ovf <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_cnt  <= '0;
            r_ovf  <= 1'b0;
            r_ptr  <= '0;
            r_len  <= cw_len;
            r_busy <= 1'b1;
            if (cw_len == '0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_SCAN;
            end
          end
        end
        ST_SCAN: begin
          if (w_issue && w_last) r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          // The final read returns here; finish once its result has drained.
          if (w_fifo_next == 2'd0) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rden       = w_issue;
  assign rdaddress  = w_issue ? r_ptr : r_rdaddr;
  assign loc_valid  = w_fifo_valid;
  assign loc_pos    = w_fifo_head;
  assign busy       = r_busy;
  assign done       = r_done;
  assign eras_count = r_cnt;
  assign overflow   = r_ovf;

endmodule
